// File: rtl/mem_write_scheduler.sv
// Arbitrates NUM_REQ vector producers onto the single memory write port and streams each
// accepted vector as LANES one-word writes. Define MEM_WR_SCHED_RR_EN for round-robin arbitration.
module mem_write_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int LANES   = 16,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_REQ-1:0]                          req_valid,
  input  logic [NUM_REQ-1:0][LANES-1:0][DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]              req_addr,
  output logic [NUM_REQ-1:0]                          req_ready,
  output logic [NUM_REQ-1:0]                          done,
  output logic                                        busy,
  output logic                                        mem_we,
  output logic [ADDR_W-1:0]                           mem_addr,
  output logic [DATA_W-1:0]                           mem_wdata
);
  localparam int OWN_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                     state, state_nxt;
  logic [LANE_W-1:0]          lane;
  logic [LANES-1:0][DATA_W-1:0] vbuf;
  logic [ADDR_W-1:0]          base;
  logic [OWN_W-1:0]           owner, gnt_idx;
  logic                       gnt_found;
  logic                       last_lane;

  assign last_lane = (lane == LANE_W'(LANES-1));
  assign busy      = (state != IDLE);

`ifdef MEM_WR_SCHED_RR_EN
  // Pointer holds the last owner; the search starts just past it.
  logic [OWN_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst)                 rr_ptr <= OWN_W'(NUM_REQ-1);
    else if (state == DONE)  rr_ptr <= owner;
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!gnt_found && req_valid[OWN_W'((int'(rr_ptr) + i) % NUM_REQ)]) begin
        gnt_found = 1'b1;
        gnt_idx   = OWN_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end
`else
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid[OWN_W'(i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = OWN_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    done      = '0;
    case (state)
      IDLE: begin
        if (gnt_found && !rst) begin
          state_nxt          = WRITE;
          req_ready[gnt_idx] = 1'b1;
        end
      end
      WRITE: if (last_lane) state_nxt = DONE;
      DONE: begin
        state_nxt   = IDLE;
        done[owner] = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane 0 is loaded straight from the winner so the first write lands the cycle after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            vbuf      <= req_data[gnt_idx];
            base      <= req_addr[gnt_idx];
            owner     <= gnt_idx;
            lane      <= '0;
            mem_we    <= 1'b1;
            mem_addr  <= req_addr[gnt_idx];
            mem_wdata <= req_data[gnt_idx][0];
          end
        end
        WRITE: begin
          if (last_lane) begin
            mem_we <= 1'b0;
          end else begin
            lane      <= lane + LANE_W'(1);
            mem_addr  <= base + ADDR_W'(lane) + ADDR_W'(1);
            mem_wdata <= vbuf[lane + LANE_W'(1)];
          end
        end
        default: ;
      endcase
    end
  end
endmodule
